// File: rtl/seg_status_display.sv
// Status FSM with a blinking 5-digit 7-seg word, plus a sequential binary-to-BCD numeric display.
// Optional macro SEG_LZB_EN blanks leading zero digits of num_seg_o.
module seg_status_display #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    pause_i,
  input  logic                    finish_i,
  input  logic                    clear_i,
  input  logic [VAL_W-1:0]        value_i,
  input  logic                    value_vld_i,
  output logic [1:0]              state_o,
  output logic                    busy_o,
  output logic [34:0]             status_seg_o,
  output logic [7*NUM_DIGITS-1:0] num_seg_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GO = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT, CV_OUT} cv_t;

  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [34:0] W_IDLE  = {7'b0101111, 7'b0000110, 7'b0001000, 7'b0100001, 7'b0010001};
  localparam logic [34:0] W_GO    = {SEG_DARK, SEG_DARK, SEG_DARK, 7'b1000010, 7'b1000000};
  localparam logic [34:0] W_PAUSE = {7'b0001100, 7'b0001000, 7'b1000001, 7'b0010010, 7'b0000110};
  localparam logic [34:0] W_DONE  = {SEG_DARK, 7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] OVF_LIM = pow10(NUM_DIGITS);

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_DARK;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] num_rst();
    logic [7*NUM_DIGITS-1:0] r;
    for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef SEG_LZB_EN
      r[7*k +: 7] = (k != 0) ? SEG_DARK : SEG_ZERO;
`else
      r[7*k +: 7] = SEG_ZERO;
`endif
    end
    return r;
  endfunction

  function automatic logic [34:0] status_word(input state_t st, input logic on);
    logic [34:0] w;
    case (st)
      ST_IDLE:  w = W_IDLE;
      ST_GO:    w = W_GO;
      ST_PAUSE: w = on ? W_PAUSE : {5{SEG_DARK}};
      default:  w = W_DONE;
    endcase
    return w;
  endfunction

  state_t                  r_state;
  logic [34:0]             r_status;
  logic [BLK_W-1:0]        r_blk_cnt;
  logic                    r_blk_on;
  cv_t                     r_cv;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_pend_vld;
  logic [VAL_W-1:0]        r_pend_val;
  logic [VAL_W-1:0]        r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic                    r_ovf;
  logic [7*NUM_DIGITS-1:0] r_num;
  logic [7*NUM_DIGITS-1:0] w_num_next;
`ifdef SEG_LZB_EN
  logic                    w_lead;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_status  <= W_IDLE;
      r_blk_cnt <= '0;
      r_blk_on  <= 1'b1;
    end else begin
      if (clear_i) r_state <= ST_IDLE;
      else begin
        case (r_state)
          ST_IDLE:  if (start_i) r_state <= ST_GO;
          ST_GO:    if (pause_i) r_state <= ST_PAUSE;
                    else if (finish_i) r_state <= ST_DONE;
          ST_PAUSE: if (pause_i) r_state <= ST_GO;
          default:  r_state <= ST_DONE;
        endcase
      end
      // Blink timer idles at 0/on outside PAUSE, so every PAUSE entry starts a fresh on-phase
      if (r_state == ST_PAUSE) begin
        if (r_blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
          r_blk_cnt <= '0;
          r_blk_on  <= ~r_blk_on;
        end else begin
          r_blk_cnt <= r_blk_cnt + BLK_W'(1);
        end
      end else begin
        r_blk_cnt <= '0;
        r_blk_on  <= 1'b1;
      end
      r_status <= status_word(r_state, r_blk_on);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cv       <= CV_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_pend_vld <= 1'b0;
      r_num      <= num_rst();
    end else begin
      case (r_cv)
        CV_IDLE: if (value_vld_i || r_pend_vld) begin
          r_cv       <= CV_LOAD;
          r_busy     <= 1'b1;
          r_pend_vld <= 1'b0;
        end
        CV_LOAD: begin
          r_cnt <= '0;
          r_cv  <= CV_SHIFT;
        end
        CV_SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(VAL_W - 1)) r_cv <= CV_OUT;
        end
        default: begin
          r_num  <= w_num_next;
          r_busy <= 1'b0;
          r_cv   <= CV_IDLE;
        end
      endcase
      if (value_vld_i && r_busy) r_pend_vld <= 1'b1;
    end
  end

  // A fresh strobe in the idle cycle is newer than any pending value, so it wins
  always_ff @(posedge clk) begin
    if (r_cv == CV_IDLE) r_bin <= value_vld_i ? value_i : r_pend_val;
    else if (r_cv == CV_SHIFT) begin
      r_bin <= r_bin << 1;
      r_bcd <= BCD_W'({dabble(r_bcd), r_bin[VAL_W-1]});
    end
    if (r_cv == CV_LOAD) begin
      r_bcd <= '0;
      r_ovf <= ({{(32-VAL_W){1'b0}}, r_bin} >= OVF_LIM);
    end
    if (value_vld_i && r_busy) r_pend_val <= value_i;
  end

  always_comb begin
    w_num_next = '0;
`ifdef SEG_LZB_EN
    w_lead = 1'b1;
`endif
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (r_ovf) w_num_next[7*k +: 7] = SEG_DASH;
`ifdef SEG_LZB_EN
      else if (w_lead && (k != 0) && (r_bcd[4*k +: 4] == 4'd0)) w_num_next[7*k +: 7] = SEG_DARK;
`endif
      else begin
`ifdef SEG_LZB_EN
        w_lead = 1'b0;
`endif
        w_num_next[7*k +: 7] = seg_digit(r_bcd[4*k +: 4]);
      end
    end
  end

  assign state_o      = r_state;
  assign busy_o       = r_busy;
  assign status_seg_o = r_status;
  assign num_seg_o    = r_num;

endmodule

// File: doc/seg_status_display.md
SEG_STATUS_DISPLAY -- requirements
Module: seg_status_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of numeric 7-seg digits (1..8).
REQ-002 SHALL have parameter VAL_W, default 14, binary value width (1..27).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per PAUSE blink half-period (>=2).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start_i  in  1  one-cycle pulse, IDLE->GO.
REQ-007 pause_i  in  1  one-cycle pulse, toggles GO/PAUSE.
REQ-008 finish_i  in  1  one-cycle pulse, GO->DONE.
REQ-009 clear_i  in  1  one-cycle pulse, any state->IDLE.
REQ-010 value_i  in  VAL_W  unsigned binary value to display.
REQ-011 value_vld_i  in  1  one-cycle strobe qualifying value_i.
REQ-012 state_o  out  2  FSM state: 0 IDLE, 1 GO, 2 PAUSE, 3 DONE.
REQ-013 busy_o  out  1  high while a BCD conversion is running.
REQ-014 status_seg_o  out  35  five status digits; bits [7k+6:7k] = digit k, digit 0 rightmost.
REQ-015 num_seg_o  out  7*NUM_DIGITS  numeric digits, same packing, digit 0 = least significant.

Function
REQ-016 All segment codes SHALL be active-low, bit order {g,f,e,d,c,b,a}; DARK=1111111, dash=0111111, 0-9 = 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
REQ-017 FSM transitions per cycle, priority clear_i > pause_i > finish_i > start_i: IDLE-start->GO; GO-pause->PAUSE; GO-finish->DONE; PAUSE-pause->GO; DONE exits only by clear_i; clear_i in any state->IDLE.
REQ-018 status_seg_o SHALL be registered and reflect the new state one edge after the transition edge.
REQ-019 Status words, digits 4..0: IDLE "rEAdY" = 0101111,0000110,0001000,0100001,0010001; GO "___GO" = DARK x3,1000010,1000000; PAUSE "PAUSE" = 0001100,0001000,1000001,0010010,0000110; DONE "_donE" = DARK,0100001,0100011,0101011,0000110.
REQ-020 In PAUSE a blink counter SHALL count 0..BLINK_DIV-1 and wrap, toggling phase on wrap; phase off SHALL drive all status digits DARK; counter and phase SHALL clear to 0/on on PAUSE entry.
REQ-021 BCD conversion SHALL be sequential shift-add-3: one load cycle, then VAL_W shift cycles, then one output-register cycle; num_seg_o updates exactly VAL_W+2 edges after the accepting value_vld_i edge.
REQ-022 busy_o SHALL rise the edge after acceptance and fall on the num_seg_o update edge.
REQ-023 value_vld_i while busy SHALL load a one-entry pending register (newer overwrites older); pending value SHALL start conversion on the cycle after busy_o falls.
REQ-024 num_seg_o SHALL change atomically, never showing partial conversion results.
REQ-025 Value >= 10^NUM_DIGITS SHALL display dash on every numeric digit.
REQ-026 Numeric conversion SHALL run independently of FSM state; clear_i SHALL NOT abort it.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, status_seg_o = "rEAdY", num_seg_o = all 0 digits (subject to REQ-029), busy_o 0, pending empty, blink counter 0, phase on.
REQ-028 Reset during conversion SHALL discard the conversion and the pending value.

Configuration
REQ-029 Macro SEG_LZB_EN: defined -> leading zero digits of num_seg_o SHALL be DARK, digit 0 always shown (value 0 shows single 0); undefined -> all NUM_DIGITS digits shown including leading zeros; dash overflow (REQ-025) unaffected.

Verification
REQ-030 Reset, then start_i, pause_i, pause_i, finish_i pulses 5 cycles apart -> state_o 0,1,2,1,3; status_seg_o matches REQ-019 one edge after each.
REQ-031 Defaults, value_i=1234 strobed -> busy_o high 16 edges; num_seg_o = 0011001,0110000,0100100,1111001 (digits 0..3) at edge 16.
REQ-032 value_i=42 then value_i=7 and 9 strobed while busy -> display 42, then 9; 7 never shown.
REQ-033 BLINK_DIV=4, enter PAUSE -> status digits alternate on 4 cycles / DARK 4 cycles; pause_i -> GO word steady.
REQ-034 value_i=10000 (NUM_DIGITS=4) -> all four digits dash; value_i=5 -> 0005, or DARK,DARK,DARK,5 with SEG_LZB_EN.
REQ-035 clear_i with pause_i same cycle in GO -> IDLE; rst_n low mid-conversion -> busy_o 0 immediately, num_seg_o reset value.
